seg_digit_driver: RTL and testbench

SEG_DIGIT_DRIVER -- requirements
Module: seg_digit_driver

---
 rtl/seg_digit_driver.sv | 143 ++++++++++++++
 tb/tb_seg_digit_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_driver.sv
// Multiplexed 7-segment digit driver: double-buffered hex data with frame-aligned updates and anti-ghost blanking.
// Optional leading-zero blanking of digits 3..1 is enabled by defining SEG_LZ_BLANK_EN.
module seg_digit_driver #(
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  SEG_ANODE,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  SEG_CATHODE,
    output logic        SEG_DP
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIG_N  = 4;

    logic [DIG_N-1:0]  r_anode_q;
    logic [CNT_W-1:0]  r_blank_cnt;
    logic [DATA_W-1:0] r_pend_data;
    logic [DIG_N-1:0]  r_pend_dp;
    logic [DATA_W-1:0] r_act_data;
    logic [DIG_N-1:0]  r_act_dp;

    logic              w_change;
    logic              w_frame;
    logic              w_busy_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] w_act_data_next;
    logic [DIG_N-1:0]  w_act_dp_next;
    logic              w_valid;
    logic [1:0]        w_sel;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg;
    logic              w_lz_blank;
    logic              w_blank;

    // Outputs are computed from next-state values so the registered outputs track anode_q/counter/active exactly.
    always_comb begin
        w_change        = (SEG_ANODE != r_anode_q);
        w_frame         = w_change && (SEG_ANODE == 4'b1110);
        w_busy_next     = load || (busy && !w_frame);
        w_act_data_next = (w_frame && busy) ? r_pend_data : r_act_data;
        w_act_dp_next   = (w_frame && busy) ? r_pend_dp   : r_act_dp;
        if (w_change) begin
            w_cnt_next = CNT_W'(BLANK_CYCLES);
        end else if (r_blank_cnt == '0) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_blank_cnt - CNT_W'(1);
        end
    end

    // Digit select from the (next) anode_q; anything but exactly one low bit is invalid.
    always_comb begin
        w_valid = 1'b1;
        w_sel   = 2'd0;
        case (SEG_ANODE)
            4'b1110: w_sel = 2'd0;
            4'b1101: w_sel = 2'd1;
            4'b1011: w_sel = 2'd2;
            4'b0111: w_sel = 2'd3;
            default: w_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_nibble = w_act_data_next[3:0];
        case (w_sel)
            2'd0: w_nibble = w_act_data_next[3:0];
            2'd1: w_nibble = w_act_data_next[7:4];
            2'd2: w_nibble = w_act_data_next[11:8];
            2'd3: w_nibble = w_act_data_next[15:12];
            default: w_nibble = w_act_data_next[3:0];
        endcase
    end

    // Hex to active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg = 7'h0E;
        case (w_nibble)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
    end

    always_comb begin
        w_lz_blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        case (w_sel)
            2'd1: w_lz_blank = (w_act_data_next[15:4] == 12'h000);
            2'd2: w_lz_blank = (w_act_data_next[15:8] == 8'h00);
            2'd3: w_lz_blank = (w_act_data_next[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
        endcase
`endif
        w_blank = !w_valid || (w_cnt_next != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode_q   <= 4'b1111;
            r_blank_cnt <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            busy        <= 1'b0;
            SEG_CATHODE <= 7'h7F;
            SEG_DP      <= 1'b1;
        end else begin
            r_anode_q   <= SEG_ANODE;
            r_blank_cnt <= w_cnt_next;
            r_act_data  <= w_act_data_next;
            r_act_dp    <= w_act_dp_next;
            busy        <= w_busy_next;
            if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
            end
            SEG_CATHODE <= (w_blank || w_lz_blank) ? 7'h7F : w_seg;
            SEG_DP      <= w_blank ? 1'b1 : ~w_act_dp_next[w_sel];
        end
    end

endmodule

// File: tb/tb_seg_digit_driver.sv
// Randomized bench for seg_digit_driver against a time-since-change / double-buffer model.
module tb_seg_digit_driver;

    localparam int B   = 2;
    localparam int SAT = 1000;
    localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anode;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic        busy;
    logic [6:0]  cath;
    logic        seg_dp;

    int n_cmp = 0;
    int n_bad = 0;

    seg_digit_driver #(.BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .SEG_ANODE(anode), .data_in(data), .dp_in(dp),
        .load(load), .busy(busy), .SEG_CATHODE(cath), .SEG_DP(seg_dp)
    );

    always #5 clk = ~clk;

    // Model: cycles elapsed since the last anode change, plus pending/active buffers.
    bit          m_valid = 1'b0;
    logic [3:0]  m_prev;
    int          m_since;
    logic        m_busy;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    logic [6:0]  exp_cath;
    logic        exp_dp;

    logic        m_chg, m_fb, m_busy_n;
    int          m_since_n;
    logic [15:0] m_act_n;
    logic [3:0]  m_adp_n;

    assign m_chg     = (anode != m_prev);
    assign m_fb      = m_chg && (anode == 4'b1110);
    assign m_since_n = m_chg ? 0 : ((m_since < SAT) ? m_since + 1 : m_since);
    assign m_busy_n  = load || (m_busy && !m_fb);
    assign m_act_n   = (m_fb && m_busy) ? m_pend : m_act;
    assign m_adp_n   = (m_fb && m_busy) ? m_pdp  : m_adp;

    function automatic int digit_idx(input logic [3:0] a);
        int zeros = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    function automatic logic [6:0] model_cath(input logic [3:0] a, input int since, input logic [15:0] act);
        int idx = digit_idx(a);
        int v = int'(act);
        if (idx < 0 || since < B) return 7'h7F;
`ifdef SEG_LZ_BLANK_EN
        if (idx > 0 && (v >> (4 * idx)) == 0) return 7'h7F;
`endif
        return SEG_TBL[(v >> (4 * idx)) & 15];
    endfunction

    function automatic logic model_dp(input logic [3:0] a, input int since, input logic [3:0] adp);
        int idx = digit_idx(a);
        if (idx < 0 || since < B) return 1'b1;
        return ~adp[idx];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b1;
            m_prev   <= 4'hF;
            m_since  <= SAT;
            m_busy   <= 1'b0;
            m_pend   <= '0;
            m_pdp    <= '0;
            m_act    <= '0;
            m_adp    <= '0;
            exp_cath <= 7'h7F;
            exp_dp   <= 1'b1;
        end else begin
            m_prev   <= anode;
            m_since  <= m_since_n;
            m_busy   <= m_busy_n;
            m_pend   <= load ? data : m_pend;
            m_pdp    <= load ? dp   : m_pdp;
            m_act    <= m_act_n;
            m_adp    <= m_adp_n;
            exp_cath <= model_cath(anode, m_since_n, m_act_n);
            exp_dp   <= model_dp(anode, m_since_n, m_adp_n);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // One clock step; outputs compared against the model every cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (m_valid) begin
            check("model_cath", 16'(cath), 16'(exp_cath));
            check("model_dp",   16'(seg_dp), 16'(exp_dp));
            check("model_busy", 16'(busy), 16'(m_busy));
        end
    endtask

    task automatic run_digit(input int d, input int n);
        anode = 4'(~(4'b0001 << d));
        repeat (n) cycle();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] p);
        data = v;
        dp   = p;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        int d;
        int dwell;
        rst = 1'b1; anode = 4'hF; data = '0; dp = '0; load = 1'b0;
        repeat (3) cycle();
        check("rst_cath", 16'(cath), 16'h7F);
        check("rst_dp",   16'(seg_dp), 16'h1);
        check("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;

        // Blank for two cycles after each change, then show active value 0.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                anode = 4'(~(4'b0001 << k));
                cycle();
                cycle();
                if (f == 0) check("blank_after_change", 16'(cath), 16'h7F);
                cycle();
                if (f == 0) check("zero_after_blank", 16'(cath), 16'h40);
                repeat (5) cycle();
            end
        end

        // Mid-frame load held off until the next frame boundary.
        run_digit(0, 8);
        run_digit(1, 3);
        pulse_load(16'h1234, 4'b0101);
        check("busy_set", 16'(busy), 16'h1);
        run_digit(1, 4);
        run_digit(2, 8);
        check("no_tear", 16'(cath), 16'h40);
        run_digit(3, 8);
        check("busy_hold", 16'(busy), 16'h1);
        run_digit(0, 3);
        check("busy_clear", 16'(busy), 16'h0);
        check("d0_is_4", 16'(cath), 16'h19);
        check("d0_dp_on", 16'(seg_dp), 16'h0);
        run_digit(0, 5);
        run_digit(1, 3);
        check("d1_is_3", 16'(cath), 16'h30);
        check("d1_dp_off", 16'(seg_dp), 16'h1);
        run_digit(1, 5);
        run_digit(2, 3);
        check("d2_is_2", 16'(cath), 16'h24);
        run_digit(2, 5);
        run_digit(3, 3);
        check("d3_is_1", 16'(cath), 16'h79);
        run_digit(3, 5);

        // Latest of two loads wins.
        run_digit(0, 8);
        run_digit(1, 2);
        pulse_load(16'hAAAA, 4'b0000);
        pulse_load(16'h5555, 4'b0000);
        run_digit(1, 4);
        run_digit(2, 8);
        run_digit(3, 8);
        run_digit(0, 3);
        check("latest_wins", 16'(cath), 16'h12);
        check("busy_clear2", 16'(busy), 16'h0);
        run_digit(0, 5);

        // Load coincident with a boundary while busy.
        run_digit(1, 4);
        pulse_load(16'h1111, 4'b0000);
        run_digit(1, 3);
        run_digit(2, 8);
        run_digit(3, 8);
        anode = 4'b1110;
        pulse_load(16'h2222, 4'b0000);
        check("coincide_busy", 16'(busy), 16'h1);
        cycle();
        cycle();
        check("old_pending_shown", 16'(cath), 16'h79);
        repeat (5) cycle();
        run_digit(1, 8);
        run_digit(2, 8);
        run_digit(3, 8);
        run_digit(0, 3);
        check("new_pending_shown", 16'(cath), 16'h24);
        check("busy_clear3", 16'(busy), 16'h0);
        run_digit(0, 5);

        // Invalid anode patterns blank everything.
        anode = 4'b1111;
        repeat (6) cycle();
        check("inv1111_cath", 16'(cath), 16'h7F);
        check("inv1111_dp", 16'(seg_dp), 16'h1);
        anode = 4'b1100;
        pulse_load(16'h0070, 4'b1111);
        repeat (6) cycle();
        check("inv1100_cath", 16'(cath), 16'h7F);
        check("inv1100_dp", 16'(seg_dp), 16'h1);

        // 0x0070: leading-zero handling on digits 3 and 2.
        run_digit(0, 8);
        run_digit(1, 3);
        check("lz_d1", 16'(cath), 16'h78);
        run_digit(1, 5);
        run_digit(2, 3);
`ifdef SEG_LZ_BLANK_EN
        check("lz_d2", 16'(cath), 16'h7F);
`else
        check("lz_d2", 16'(cath), 16'h40);
`endif
        check("lz_dp", 16'(seg_dp), 16'h0);
        run_digit(2, 5);
        run_digit(3, 8);

        // Random rotation, dwell, invalid patterns, loads and resets.
        d = 0;
        dwell = 0;
        for (int c = 0; c < 4000; c++) begin
            if (dwell == 0) begin
                dwell = int'($urandom_range(1, 6));
                if ($urandom_range(0, 9) == 0) begin
                    anode = 4'($urandom);
                end else begin
                    d = (d + 1) % 4;
                    anode = 4'(~(4'b0001 << d));
                end
            end
            dwell--;
            load = ($urandom_range(0, 7) == 0);
            data = 16'($urandom);
            dp   = 4'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
